emmc_resp_rx: RTL and testbench

EMMC_RESP_RX -- requirements
Module: emmc_resp_rx

---
 rtl/emmc_pkg.sv | 32 +++
 rtl/emmc_crc7_acc.sv | 35 +++
 rtl/emmc_resp_rx.sv | 147 ++++++++++++++
 tb/tb_emmc_resp_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/emmc_pkg.sv
// ---------------------------------------------------------------------------
// emmc_pkg
// Shared definitions for the eMMC command-response receiver:
//   - state_t      : receiver state encoding
//   - FRAME_BITS   : response frame length (48)
//   - CRC_FIRST    : first frame bit that is not covered by the CRC (40)
//   - END_BIT      : index of the end bit (47)
//   - CRC7_POLY    : x^7 + x^3 + 1, low 7 coefficients
//   - crc7_step()  : one serial CRC7 update
// ---------------------------------------------------------------------------
package emmc_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      RECV       = 2'd2
   } state_t;

   localparam int         FRAME_BITS = 48;
   localparam int         CRC_FIRST  = 40;
   localparam int         END_BIT    = 47;
   localparam logic [6:0] CRC7_POLY  = 7'h09;

   // Shift left by one; when the feedback bit is set, fold in the polynomial.
   // This gives c[3] = fb ^ c[2] and c[0] = fb, all other bits plain shift.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
      logic fb;
      fb = d ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/emmc_crc7_acc.sv
// ---------------------------------------------------------------------------
// emmc_crc7_acc
// Serial CRC7 accumulator (x^7 + x^3 + 1, initial value 0).
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset, clears the CRC
//   clr  - synchronous clear (takes priority over en)
//   en   - fold din into the CRC on this edge
//   din  - serial data bit
//   crc  - current CRC value
// ---------------------------------------------------------------------------
module emmc_crc7_acc
   import emmc_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         crc <= 7'h00;
      end else if (clr) begin
         crc <= 7'h00;
      end else if (en) begin
         crc <= crc7_step(crc, din);
      end
   end

endmodule

// File: rtl/emmc_resp_rx.sv
// ---------------------------------------------------------------------------
// emmc_resp_rx
// Receives one 48-bit eMMC response frame from the serial CMD line after each
// start request, checks CRC7, end bit and transmission bit, and presents the
// decoded fields with a one-cycle resp_valid pulse.
// Parameters:
//   TIMEOUT_CYCLES - max cycles waiting for the start bit
//   EXPECT_TX      - required value of the transmission bit (frame bit 1)
// Ports:
//   clk, rstn      - clock, asynchronous active-low reset
//   start          - arm reception (only honoured in IDLE)
//   cmd_in         - serial CMD line, synchronous to clk
//   busy           - state is not IDLE
//   resp_valid     - one-cycle pulse, frame complete
//   resp_index     - frame bits 2..7
//   resp_arg       - frame bits 8..39
//   resp_crc       - received CRC, frame bits 40..46
//   crc_err        - received CRC differs from computed CRC
//   frame_err      - end bit is 0 or transmission bit != EXPECT_TX
//   timeout        - one-cycle pulse, wait for the start bit expired
// ---------------------------------------------------------------------------
module emmc_resp_rx
   import emmc_pkg::*;
#(
   parameter int   TIMEOUT_CYCLES = 64,
   parameter logic EXPECT_TX      = 1'b0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        cmd_in,
   output logic        busy,
   output logic        resp_valid,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg,
   output logic [6:0]  resp_crc,
   output logic        crc_err,
   output logic        frame_err,
   output logic        timeout
);

   localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = $clog2(FRAME_BITS);
   // Holds frame bits 1..46; bit k sits at index SHIFT_W-k once bit 46 is in.
   localparam int SHIFT_W = END_BIT - 1;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     bit_cnt;
   logic [TO_W-1:0]      to_cnt;
   logic [SHIFT_W-1:0]   shreg;
   logic [6:0]           crc_q;

   logic arm, start_bit, to_hit, last_bit, crc_en;

   assign arm       = (state == IDLE) && start;
   assign start_bit = (state == WAIT_START) && !cmd_in;
   assign to_hit    = (state == WAIT_START) && cmd_in &&
                      (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign last_bit  = (state == RECV) && (bit_cnt == CNT_W'(END_BIT));
   // Start bit plus frame bits 1..39 feed the CRC; CRC and end bit do not.
   assign crc_en    = start_bit ||
                      ((state == RECV) && (bit_cnt < CNT_W'(CRC_FIRST)));

   emmc_crc7_acc u_crc (
      .clk  (clk),
      .rstn (rstn),
      .clr  (arm),
      .en   (crc_en),
      .din  (cmd_in),
      .crc  (crc_q)
   );

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   // NOTE: a default assignment at the top of every combinational block keeps
   // each path assigned, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:       if (start) state_nxt = WAIT_START;
         WAIT_START: if (!cmd_in)     state_nxt = RECV;
                     else if (to_hit) state_nxt = IDLE;
         RECV:       if (last_bit) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = (state != IDLE);
   end

   // Counters and shift register
   // NOTE: the shift register is reset along with the control state even
   // though its contents are only consumed at the end bit; it is small, and a
   // defined value keeps reset behaviour identical across tools.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         to_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         if (arm)
            to_cnt <= '0;
         else if ((state == WAIT_START) && cmd_in)
            to_cnt <= to_cnt + TO_W'(1);

         if (start_bit)
            bit_cnt <= CNT_W'(1);
         else if (state == RECV)
            bit_cnt <= bit_cnt + CNT_W'(1);

         if ((state == RECV) && !last_bit)
            shreg <= {shreg[SHIFT_W-2:0], cmd_in};
      end
   end

   // Result outputs: only written on the end-bit edge, so they hold the
   // previous frame for the whole of the next reception.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         resp_valid <= 1'b0;
         timeout    <= 1'b0;
         resp_index <= '0;
         resp_arg   <= '0;
         resp_crc   <= '0;
         crc_err    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         resp_valid <= last_bit;
         timeout    <= to_hit;
         if (last_bit) begin
            resp_index <= shreg[SHIFT_W-2 -: 6];
            resp_arg   <= shreg[SHIFT_W-8 -: 32];
            resp_crc   <= shreg[6:0];
            crc_err    <= (crc_q != shreg[6:0]);
            frame_err  <= !cmd_in || (shreg[SHIFT_W-1] != EXPECT_TX);
         end
      end
   end

endmodule

// File: tb/tb_emmc_resp_rx.sv
// ---------------------------------------------------------------------------
// tb_emmc_resp_rx
// Two receivers share one CMD line: d1 expects transmission bit 1, d0 uses the
// default parameters (transmission bit 0), so every device-to-host frame is a
// transmission-bit error for d0. Inputs change and outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_emmc_resp_rx;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic cmd_in = 1'b1;

   logic        busy1, rv1, cerr1, ferr1, to1;
   logic [5:0]  idx1;
   logic [31:0] arg1;
   logic [6:0]  crc1;
   logic        busy0, rv0, cerr0, ferr0, to0;
   logic [5:0]  idx0;
   logic [31:0] arg0;
   logic [6:0]  crc0;

   int total = 0;
   int bad   = 0;

   // Last decoded result expected on d1; must hold through the next frame.
   logic [5:0]  prev_idx = '0;
   logic [31:0] prev_arg = '0;
   logic [6:0]  prev_crc = '0;

   bit early, held_bad, busy_gap;

   always #5 clk = ~clk;

   emmc_resp_rx #(.TIMEOUT_CYCLES(64), .EXPECT_TX(1'b1)) d1 (
      .clk(clk), .rstn(rstn), .start(start), .cmd_in(cmd_in),
      .busy(busy1), .resp_valid(rv1), .resp_index(idx1), .resp_arg(arg1),
      .resp_crc(crc1), .crc_err(cerr1), .frame_err(ferr1), .timeout(to1)
   );

   emmc_resp_rx d0 (
      .clk(clk), .rstn(rstn), .start(start), .cmd_in(cmd_in),
      .busy(busy0), .resp_valid(rv0), .resp_index(idx0), .resp_arg(arg0),
      .resp_crc(crc0), .crc_err(cerr0), .frame_err(ferr0), .timeout(to0)
   );

   // Arm, wait idle cycles with the line high, then shift the 48 frame bits.
   // Returns at the falling edge after the end-bit edge, where resp_valid
   // must be high (start-bit edge + 47).
   task automatic send_frame(input logic [47:0] f, input int idle, input bit arm_now);
      early    = 1'b0;
      held_bad = 1'b0;
      busy_gap = 1'b0;
      if (!arm_now) @(negedge clk);
      start  = 1'b1;
      cmd_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (idle) @(negedge clk);
      for (int k = 0; k < 48; k++) begin
         cmd_in = f[47-k];
         @(negedge clk);
         if (k < 47) begin
            if (rv1 || rv0) early = 1'b1;
            if (!busy1) busy_gap = 1'b1;
            if ({idx1, arg1, crc1} !== {prev_idx, prev_arg, prev_crc}) held_bad = 1'b1;
         end
      end
      cmd_in = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({busy1, rv1, idx1, arg1, crc1, cerr1, ferr1, to1} !== '0) begin
         bad++;
         $display("FAIL reset_d1: got %h want 0", {busy1, rv1, idx1, arg1, crc1, cerr1, ferr1, to1});
      end
      total++;
      if ({busy0, rv0, idx0, arg0, crc0, cerr0, ferr0, to0} !== '0) begin
         bad++;
         $display("FAIL reset_d0: got %h want 0", {busy0, rv0, idx0, arg0, crc0, cerr0, ferr0, to0});
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_cmd0();
      send_frame(48'h400000000095, 3, 1'b0);
      total++;
      if (rv1 !== 1'b1 || early) begin
         bad++;
         $display("FAIL cmd0_latency: resp_valid=%b early=%b want 1/0", rv1, early);
      end
      total++;
      if ({idx1, arg1, crc1} !== {6'd0, 32'h0, 7'h4A}) begin
         bad++;
         $display("FAIL cmd0_fields: got %h/%h/%h want 00/00000000/4a", idx1, arg1, crc1);
      end
      total++;
      if ({cerr1, ferr1} !== 2'b00) begin
         bad++;
         $display("FAIL cmd0_errs: crc_err=%b frame_err=%b want 0/0", cerr1, ferr1);
      end
      total++;
      if ({rv0, cerr0, ferr0} !== 3'b101) begin
         bad++;
         $display("FAIL cmd0_tx_mismatch_d0: valid/crc_err/frame_err=%b want 101", {rv0, cerr0, ferr0});
      end
      total++;
      if (held_bad || busy_gap) begin
         bad++;
         $display("FAIL cmd0_hold_busy: held_bad=%b busy_gap=%b want 0/0", held_bad, busy_gap);
      end
      prev_idx = 6'd0; prev_arg = 32'h0; prev_crc = 7'h4A;
      @(negedge clk);
      total++;
      if ({rv1, busy1, idx1, crc1} !== {1'b0, 1'b0, 6'd0, 7'h4A}) begin
         bad++;
         $display("FAIL cmd0_pulse_end: valid=%b busy=%b idx=%h crc=%h want 0 0 00 4a", rv1, busy1, idx1, crc1);
      end
   endtask

   // CMD8 response, then a bad-CRC frame armed in the resp_valid cycle.
   task automatic test_back_to_back();
      send_frame(48'h48000001AA87, 0, 1'b0);
      total++;
      if ({rv1, idx1, arg1, crc1, cerr1, ferr1} !== {1'b1, 6'd8, 32'h000001AA, 7'h43, 2'b00} || early) begin
         bad++;
         $display("FAIL cmd8: got v=%b %h/%h/%h ce=%b fe=%b want 1 08/000001aa/43 0 0",
                  rv1, idx1, arg1, crc1, cerr1, ferr1);
      end
      total++;
      if (held_bad) begin
         bad++;
         $display("FAIL cmd8_hold: outputs changed during reception, want held");
      end
      prev_idx = 6'd8; prev_arg = 32'h000001AA; prev_crc = 7'h43;
      send_frame(48'h400000000097, 0, 1'b1);
      total++;
      if ({rv1, idx1, arg1, crc1} !== {1'b1, 6'd0, 32'h0, 7'h4B} || early) begin
         bad++;
         $display("FAIL b2b_fields: got v=%b %h/%h/%h want 1 00/00000000/4b", rv1, idx1, arg1, crc1);
      end
      total++;
      if ({cerr1, ferr1} !== 2'b10) begin
         bad++;
         $display("FAIL b2b_crc_err: crc_err=%b frame_err=%b want 1/0", cerr1, ferr1);
      end
      total++;
      if (held_bad) begin
         bad++;
         $display("FAIL b2b_hold: outputs changed during reception, want held");
      end
      prev_idx = 6'd0; prev_arg = 32'h0; prev_crc = 7'h4B;
   endtask

   task automatic test_end_bit_err();
      send_frame(48'h400000000094, 2, 1'b0);
      total++;
      if ({rv1, crc1, cerr1, ferr1} !== {1'b1, 7'h4A, 2'b01} || early) begin
         bad++;
         $display("FAIL end_bit_err: got v=%b crc=%h ce=%b fe=%b want 1 4a 0 1", rv1, crc1, cerr1, ferr1);
      end
      prev_idx = 6'd0; prev_arg = 32'h0; prev_crc = 7'h4A;
   endtask

   task automatic test_timeout();
      int to_at = -1;
      int to_pulses = 0;
      int rv_seen = 0;
      bit busy63 = 1'b0;
      bit busy64 = 1'b1;
      bit to1_64 = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      cmd_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         start = (n == 10);  // must be ignored in WAIT_START
         @(negedge clk);
         if (to0) begin
            to_pulses++;
            if (to_at < 0) to_at = n;
         end
         if (rv0 || rv1) rv_seen++;
         if (n == 63) busy63 = busy0;
         if (n == 64) begin
            busy64 = busy0;
            to1_64 = to1;
         end
      end
      start = 1'b0;
      total++;
      if (to_at != 64 || to_pulses != 1 || !to1_64) begin
         bad++;
         $display("FAIL timeout_pulse: at=%0d pulses=%0d d1=%b want 64 1 1", to_at, to_pulses, to1_64);
      end
      total++;
      if (!busy63 || busy64 || rv_seen != 0) begin
         bad++;
         $display("FAIL timeout_busy: busy63=%b busy64=%b valid=%0d want 1 0 0", busy63, busy64, rv_seen);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [47:0] f;
      int rv_seen = 0;
      f = 48'h48000001AA87;
      @(negedge clk);
      start  = 1'b1;
      cmd_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         cmd_in = f[47-k];
         @(negedge clk);
      end
      total++;
      if (busy1 !== 1'b1) begin
         bad++;
         $display("FAIL mid_frame_busy: busy=%b want 1", busy1);
      end
      rstn = 1'b0;
      #1;
      total++;
      if ({busy1, rv1, idx1, arg1, crc1, cerr1, ferr1, to1,
           busy0, rv0, idx0, arg0, crc0, cerr0, ferr0, to0} !== '0) begin
         bad++;
         $display("FAIL mid_frame_reset: d1=%h d0=%h want 0",
                  {busy1, rv1, idx1, arg1, crc1, cerr1, ferr1, to1},
                  {busy0, rv0, idx0, arg0, crc0, cerr0, ferr0, to0});
      end
      for (int k = 21; k < 48; k++) begin
         if (k == 23) rstn = 1'b1;
         cmd_in = f[47-k];
         @(negedge clk);
         if (rv1 || rv0 || busy1) rv_seen++;
      end
      cmd_in = 1'b1;
      total++;
      if (rv_seen != 0) begin
         bad++;
         $display("FAIL mid_frame_discard: valid/busy seen %0d cycles want 0", rv_seen);
      end
      prev_idx = 6'd0; prev_arg = 32'h0; prev_crc = 7'h00;
      send_frame(f, 1, 1'b0);
      total++;
      if ({rv1, idx1, arg1, crc1, cerr1, ferr1} !== {1'b1, 6'd8, 32'h000001AA, 7'h43, 2'b00} ||
          early || held_bad) begin
         bad++;
         $display("FAIL after_reset_frame: got v=%b %h/%h/%h ce=%b fe=%b want 1 08/000001aa/43 0 0",
                  rv1, idx1, arg1, crc1, cerr1, ferr1);
      end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_back_to_back();
      test_end_bit_err();
      test_timeout();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
